// File: rtl/rf_wb_arb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default data and address widths
//   NUM_REG                 : register count for the default address width
//   gnt_e                   : grant selection produced by the arbiter
package rf_wb_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REG    = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } gnt_e;

endpackage

// File: rtl/rf_wb_hold.sv
// One-entry holding register for a writeback port.
// Captures (addr, data) on valid_i & ready_o and releases the entry when granted.
// A grant and a new capture in the same cycle leave the entry full with the
// new request, so a continuously granted port sustains one transfer per cycle.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   valid_i          upstream request valid
//   addr_i, data_i   upstream destination register and write data
//   grant_i          entry chosen by the arbiter this cycle (only when hv_o=1)
//   ready_o          ~hv | grant
//   hv_o             entry holds a buffered write
//   addr_o, data_o   buffered destination register and data
module rf_wb_hold #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              grant_i,
    output logic              ready_o,
    output logic              hv_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              hv_q, hv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cap;

    assign ready_o = ~hv_q | grant_i;
    assign cap     = valid_i & ready_o;

    always_comb begin
        hv_d   = hv_q;
        addr_d = addr_q;
        data_d = data_q;
        if (grant_i) begin
            hv_d = 1'b0;
        end
        if (cap) begin
            hv_d   = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            hv_q   <= hv_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign hv_o   = hv_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/rf_wb_arb.sv
// Two-port register-file writeback arbiter (port 0 = ALU, port 1 = load).
// Each port buffers one write; one buffered write per cycle is issued to the
// registered r3_* write port. Equal-address entries issue oldest first.
// Writes to register 0 are consumed without asserting r3_wr.
// Build option: define RF_WB_ARB_RR_EN for round-robin arbitration between
// distinct-address entries; otherwise port 1 has fixed priority.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   p0_valid/addr/data/ready    ALU writeback handshake
//   p1_valid/addr/data/ready    load writeback handshake
//   stall                       suppress grants (captures into empty entries continue)
//   r3_wr, r3_addr, r3_din      registered register-file write port
//   pend_mask                   registers with a buffered or issuing write (bit 0 always 0)
module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p0_valid,
    input  logic [ADDR_W-1:0]        p0_addr,
    input  logic [DATA_W-1:0]        p0_data,
    output logic                     p0_ready,
    input  logic                     p1_valid,
    input  logic [ADDR_W-1:0]        p1_addr,
    input  logic [DATA_W-1:0]        p1_data,
    output logic                     p1_ready,
    input  logic                     stall,
    output logic                     r3_wr,
    output logic [ADDR_W-1:0]        r3_addr,
    output logic [DATA_W-1:0]        r3_din,
    output logic [(1<<ADDR_W)-1:0]   pend_mask
);

    localparam int NREG = 1 << ADDR_W;

    logic              hv0, hv1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] data0, data1;
    logic              g0, g1;
    gnt_e              gnt;

    // age_q = 1 when the port 1 entry was captured before the port 0 entry
    logic              age_q, age_d;
    logic              old0, old1;

    logic              r3_wr_q, r3_wr_d;
    logic [ADDR_W-1:0] r3_addr_q, r3_addr_d;
    logic [DATA_W-1:0] r3_din_q, r3_din_d;

    rf_wb_hold #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (p0_valid),
        .addr_i  (p0_addr),
        .data_i  (p0_data),
        .grant_i (g0),
        .ready_o (p0_ready),
        .hv_o    (hv0),
        .addr_o  (addr0),
        .data_o  (data0)
    );

    rf_wb_hold #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (p1_valid),
        .addr_i  (p1_addr),
        .data_i  (p1_data),
        .grant_i (g1),
        .ready_o (p1_ready),
        .hv_o    (hv1),
        .addr_o  (addr1),
        .data_o  (data1)
    );

`ifdef RF_WB_ARB_RR_EN
    // rr_q = 0 prefers port 1, rr_q = 1 prefers port 0
    logic rr_q, rr_d;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (!stall) begin
            if (hv0 && hv1) begin
                if (addr0 == addr1) begin
                    // same destination: preserve write order
                    gnt = age_q ? GNT_P1 : GNT_P0;
                end else begin
`ifdef RF_WB_ARB_RR_EN
                    gnt = rr_q ? GNT_P0 : GNT_P1;
`else
                    gnt = GNT_P1;
`endif
                end
            end else if (hv0) begin
                gnt = GNT_P0;
            end else if (hv1) begin
                gnt = GNT_P1;
            end
        end
    end

    assign g0 = (gnt == GNT_P0);
    assign g1 = (gnt == GNT_P1);

`ifdef RF_WB_ARB_RR_EN
    always_comb begin
        rr_d = rr_q;
        if ((g0 && rr_q) || (g1 && !rr_q)) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // An entry that survives this edge untouched is older than any entry
    // captured at this edge; simultaneous captures treat port 0 as older.
    assign old0 = hv0 & ~g0;
    assign old1 = hv1 & ~g1;

    always_comb begin
        age_d = age_q;
        if (!(old0 && old1)) begin
            age_d = old1 & ~old0;
        end
    end

    always_comb begin
        r3_wr_d   = 1'b0;
        r3_addr_d = r3_addr_q;
        r3_din_d  = r3_din_q;
        if (g0 || g1) begin
            r3_addr_d = g1 ? addr1 : addr0;
            r3_din_d  = g1 ? data1 : data0;
            r3_wr_d   = (r3_addr_d != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q     <= 1'b0;
            r3_wr_q   <= 1'b0;
            r3_addr_q <= '0;
            r3_din_q  <= '0;
        end else begin
            age_q     <= age_d;
            r3_wr_q   <= r3_wr_d;
            r3_addr_q <= r3_addr_d;
            r3_din_q  <= r3_din_d;
        end
    end

    assign r3_wr   = r3_wr_q;
    assign r3_addr = r3_addr_q;
    assign r3_din  = r3_din_q;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_mask[gi] = 1'b0;
            end else begin : g_bit
                assign pend_mask[gi] = (hv0     && (addr0     == ADDR_W'(gi))) ||
                                       (hv1     && (addr1     == ADDR_W'(gi))) ||
                                       (r3_wr_q && (r3_addr_q == ADDR_W'(gi)));
            end
        end
    endgenerate

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed testbench for rf_wb_arb with a write scoreboard.
module tb_rf_wb_arb;
    import rf_wb_arb_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_valid, p1_valid, p0_ready, p1_ready;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_data, p1_data;
    logic          stall;
    logic          r3_wr;
    logic [AW-1:0] r3_addr;
    logic [DW-1:0] r3_din;
    logic [NUM_REG-1:0] pend_mask;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];
    logic [DW-1:0] rf_model [NUM_REG];

    always #5 clk = ~clk;

    rf_wb_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_valid  (p0_valid),
        .p0_addr   (p0_addr),
        .p0_data   (p0_data),
        .p0_ready  (p0_ready),
        .p1_valid  (p1_valid),
        .p1_addr   (p1_addr),
        .p1_data   (p1_data),
        .p1_ready  (p1_ready),
        .stall     (stall),
        .r3_wr     (r3_wr),
        .r3_addr   (r3_addr),
        .r3_din    (r3_din),
        .pend_mask (pend_mask)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_valid = v;
        p0_addr  = a;
        p0_data  = d;
    endtask

    task automatic drv1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_valid = v;
        p1_addr  = a;
        p1_data  = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: each issued write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && r3_wr) begin
            $display("write addr=%0d data=%08h", r3_addr, r3_din);
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL spurious_wr observed addr=%0d data=%0h expected=none", r3_addr, r3_din);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(r3_addr), 64'(e.addr));
                chk("wr_data", 64'(r3_din), 64'(e.data));
            end
            rf_model[r3_addr] = r3_din;
        end
    end

    initial begin
        logic acc0, acc1;
        int   idx0, idx1;

        rst_n = 1'b0;
        stall = 1'b0;
        drv0(1'b0, '0, '0);
        drv1(1'b0, '0, '0);
        for (int i = 0; i < NUM_REG; i++) rf_model[i] = '0;

        // reset: requests are ignored, ready may be high, nothing pending
        step();
        drv0(1'b1, 5'd9, 32'h55);
        step();
        step();
        chk("rst_r3_wr", 64'(r3_wr), 64'h0);
        chk("rst_pend", 64'(pend_mask), 64'h0);
        chk("rst_p0_ready", 64'(p0_ready), 64'h1);
        chk("rst_p1_ready", 64'(p1_ready), 64'h1);
        drv0(1'b0, '0, '0);
        rst_n = 1'b1;
        step();
        chk("post_rst_r3_wr", 64'(r3_wr), 64'h0);
        chk("post_rst_pend", 64'(pend_mask), 64'h0);

        // single write, two-edge latency, pend_mask tracking
        drv0(1'b1, 5'd5, 32'h1234);
        push(5'd5, 32'h1234);
        step();
        drv0(1'b0, '0, '0);
        chk("w5_pend_cap", 64'(pend_mask), 64'h20);
        chk("w5_wr_early", 64'(r3_wr), 64'h0);
        chk("w5_ready", 64'(p0_ready), 64'h1);
        step();
        chk("w5_wr", 64'(r3_wr), 64'h1);
        chk("w5_addr", 64'(r3_addr), 64'h5);
        chk("w5_din", 64'(r3_din), 64'h1234);
        chk("w5_pend_wr", 64'(pend_mask), 64'h20);
        step();
        chk("w5_wr_done", 64'(r3_wr), 64'h0);
        chk("w5_pend_done", 64'(pend_mask), 64'h0);

        // register 0 write is consumed silently
        drv0(1'b1, 5'd0, 32'hFFFF);
        step();
        drv0(1'b0, '0, '0);
        chk("r0_ready_cap", 64'(p0_ready), 64'h1);
        chk("r0_pend_cap", 64'(pend_mask), 64'h0);
        step();
        chk("r0_wr", 64'(r3_wr), 64'h0);
        chk("r0_ready", 64'(p0_ready), 64'h1);
        chk("r0_pend", 64'(pend_mask), 64'h0);
        step();
        chk("r0_wr_late", 64'(r3_wr), 64'h0);

        // both ports streaming to distinct registers
`ifdef RF_WB_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            push(5'd2, 32'(32'h200 + i));
            push(5'd1, 32'(32'h100 + i));
        end
`else
        for (int i = 0; i < 4; i++) push(5'd2, 32'(32'h200 + i));
        for (int i = 0; i < 4; i++) push(5'd1, 32'(32'h100 + i));
`endif
        idx0 = 0;
        idx1 = 0;
        drv0(1'b1, 5'd1, 32'h100);
        drv1(1'b1, 5'd2, 32'h200);
        for (int c = 0; c < 12; c++) begin
            acc0 = p0_valid && p0_ready;
            acc1 = p1_valid && p1_ready;
            step();
            if (acc0) begin
                idx0++;
                if (idx0 < 4) drv0(1'b1, 5'd1, 32'(32'h100 + idx0));
                else          drv0(1'b0, '0, '0);
            end
            if (acc1) begin
                idx1++;
                if (idx1 < 4) drv1(1'b1, 5'd2, 32'(32'h200 + idx1));
                else          drv1(1'b0, '0, '0);
            end
        end
        step();
        chk("stream_drained", 64'(exp_q.size()), 64'h0);
        chk("stream_pend", 64'(pend_mask), 64'h0);

        // same register from both ports under stall: older first, then release
        stall = 1'b1;
        drv0(1'b1, 5'd7, 32'hA);
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        step();
        drv0(1'b0, '0, '0);
        drv1(1'b1, 5'd7, 32'hB);
        chk("st_p0_ready_full", 64'(p0_ready), 64'h0);
        chk("st_p1_ready_empty", 64'(p1_ready), 64'h1);
        step();
        drv1(1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            chk("st_wr", 64'(r3_wr), 64'h0);
            chk("st_p0_ready", 64'(p0_ready), 64'h0);
            chk("st_p1_ready", 64'(p1_ready), 64'h0);
            chk("st_pend", 64'(pend_mask), 64'h80);
            step();
        end
        stall = 1'b0;
        chk("st_rel_wr", 64'(r3_wr), 64'h0);
        step();
        chk("st_wr1", 64'(r3_wr), 64'h1);
        chk("st_din1", 64'(r3_din), 64'hA);
        step();
        chk("st_wr2", 64'(r3_wr), 64'h1);
        chk("st_din2", 64'(r3_din), 64'hB);
        step();
        chk("st_wr_end", 64'(r3_wr), 64'h0);
        chk("reg7_final", 64'(rf_model[7]), 64'hB);

        // reset while both entries are full discards them
        stall = 1'b1;
        drv0(1'b1, 5'd3, 32'h33);
        drv1(1'b1, 5'd4, 32'h44);
        step();
        drv0(1'b0, '0, '0);
        drv1(1'b0, '0, '0);
        chk("rb_p0_ready", 64'(p0_ready), 64'h0);
        chk("rb_p1_ready", 64'(p1_ready), 64'h0);
        chk("rb_pend", 64'(pend_mask), 64'h18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_p0_ready", 64'(p0_ready), 64'h1);
        chk("ra_p1_ready", 64'(p1_ready), 64'h1);
        chk("ra_pend", 64'(pend_mask), 64'h0);
        chk("ra_wr", 64'(r3_wr), 64'h0);
        step();
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ra_no_wr", 64'(r3_wr), 64'h0);
        end
        chk("final_sb_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
